// File: rtl/sccb_target_if.sv
// Host-side view of the SCCB target: write strobes out, debug map read port.
interface sccb_target_if;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;

    modport slave (
        output wr_strobe, wr_addr, wr_data, busy, rd_data,
        input  rd_addr
    );

    modport master (
        input  wr_strobe, wr_addr, wr_data, busy, rd_data,
        output rd_addr
    );
endinterface

// File: rtl/sccb_target.sv
// SCCB/I2C responder with a 256x8 register map.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | bus free or frame ignored, SDA released
// ADDR       | shifting in device address + R/W
// ADDR_ACK   | holding SDA low for the address ACK clock
// PTR        | shifting in register pointer
// PTR_ACK    | holding SDA low for the pointer ACK clock
// WDATA      | shifting in a data byte, written on its 8th rising SCL
// WDATA_ACK  | holding SDA low for the data ACK clock
// RDATA      | driving map[ptr] MSB first
// RDATA_ACK  | SDA released, sampling master ACK/NACK
// WAIT_STOP  | not addressed or read finished, waiting for STOP/START
module sccb_target #(
    parameter logic [6:0] DEV_ADDR = 7'h21,
    parameter logic [7:0] RST_VAL  = 8'h00,
    parameter int         FILT_LEN = 3
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire          sda_io,
    inout  wire          scl_io,
    sccb_target_if.slave host
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            ptr_q, ptr_d;
    logic                  nack_q, nack_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [7:0]            wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic [1:0]            scl_sync_q, sda_sync_q;
    logic [FILT_LEN-1:0]   scl_hist_q, sda_hist_q;
    logic                  scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;
    logic                  scl_prev_q, sda_prev_q;
    logic [7:0]            map_q [256];
    logic                  map_we;
    logic [7:0]            shift_in;

    logic scl_rise, scl_fall, start_det, stop_det;

    // Open-drain: SDA only ever pulled low, SCL never driven (no stretching).
    assign sda_io = sda_oe_q ? 1'b0 : 1'bz;
    assign scl_io = 1'bz;

    assign scl_rise  = scl_flt_q & ~scl_prev_q;
    assign scl_fall  = ~scl_flt_q & scl_prev_q;
    // START/STOP need SCL high on both the previous and current filtered sample.
    assign start_det = scl_flt_q & scl_prev_q & sda_prev_q & ~sda_flt_q;
    assign stop_det  = scl_flt_q & scl_prev_q & ~sda_prev_q & sda_flt_q;
    assign shift_in  = {shift_q[6:0], sda_flt_q};

    assign host.wr_strobe = wr_strobe_q;
    assign host.wr_addr   = wr_addr_q;
    assign host.wr_data   = wr_data_q;
    assign host.busy      = (state_q != S_IDLE);
    assign host.rd_data   = map_q[host.rd_addr];

    // Filtered line only follows the synchronised pin once FILT_LEN samples agree.
    always_comb begin
        scl_flt_d = scl_flt_q;
        sda_flt_d = sda_flt_q;
        if (&scl_hist_q)       scl_flt_d = 1'b1;
        else if (~|scl_hist_q) scl_flt_d = 1'b0;
        if (&sda_hist_q)       sda_flt_d = 1'b1;
        else if (~|sda_hist_q) sda_flt_d = 1'b0;
    end

    // State register, bus input path and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            nack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_hist_q  <= '1;
            sda_hist_q  <= '1;
            scl_flt_q   <= 1'b1;
            sda_flt_q   <= 1'b1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            for (int i = 0; i < 256; i++) map_q[i] <= RST_VAL;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            nack_q      <= nack_d;
            sda_oe_q    <= sda_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            scl_sync_q  <= {scl_sync_q[0], scl_io};
            sda_sync_q  <= {sda_sync_q[0], sda_io};
            scl_hist_q  <= {scl_hist_q[FILT_LEN-2:0], scl_sync_q[1]};
            sda_hist_q  <= {sda_hist_q[FILT_LEN-2:0], sda_sync_q[1]};
            scl_flt_q   <= scl_flt_d;
            sda_flt_q   <= sda_flt_d;
            scl_prev_q  <= scl_flt_q;
            sda_prev_q  <= sda_flt_q;
            if (map_we) map_q[ptr_q] <= shift_in;
        end
    end

    // Next state: START/STOP override everything, otherwise advance on SCL falls.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = S_ADDR;
        end else if (stop_det) begin
            state_d = S_IDLE;
        end else if (scl_fall) begin
            case (state_q)
                S_ADDR:      if (bit_cnt_q == 4'd8)
                                 state_d = (shift_q[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
                S_ADDR_ACK:  state_d = shift_q[0] ? S_RDATA : S_PTR;
                S_PTR:       if (bit_cnt_q == 4'd8) state_d = S_PTR_ACK;
                S_PTR_ACK:   state_d = S_WDATA;
                S_WDATA:     if (bit_cnt_q == 4'd8) state_d = S_WDATA_ACK;
                S_WDATA_ACK: state_d = S_WDATA;
                S_RDATA:     if (bit_cnt_q == 4'd7) state_d = S_RDATA_ACK;
                S_RDATA_ACK: state_d = nack_q ? S_WAIT_STOP : S_RDATA;
                default:     state_d = state_q;
            endcase
        end
    end

    // Datapath: shifting, pointer, map writes and SDA drive (changed only on SCL falls).
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        nack_d      = nack_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        map_we      = 1'b0;
        if (start_det || stop_det) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && state_q == S_PTR) ptr_d = shift_in;
                        if (bit_cnt_q == 4'd7 && state_q == S_WDATA) begin
                            map_we      = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = ptr_q;
                            wr_data_d   = shift_in;
                            ptr_d       = ptr_q + 8'd1;
                        end
                    end
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = (state_q != S_ADDR) || (shift_q[7:1] == DEV_ADDR);
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        if (shift_q[0]) begin
                            shift_d  = map_q[ptr_q];
                            sda_oe_d = ~map_q[ptr_q][7];
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        nack_d = sda_flt_q;
                        ptr_d  = ptr_q + 8'd1;
                    end
                    if (scl_fall && !nack_q) begin
                        bit_cnt_d = '0;
                        shift_d   = map_q[ptr_q];
                        sda_oe_d  = ~map_q[ptr_q][7];
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

endmodule
